// File: rtl/ldpc_qkd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ldpc_qkd_pkg
// Description : Shared definitions for the decoder message write-back path.
//               Holds default geometry, derived constants (circulant size,
//               fields per RAM word, input field width), the write-back FSM
//               state type and small helper functions for the derivations.
// Revision    : 1.0 - initial release
// ============================================================================
package ldpc_qkd_pkg;

  // Default geometry of the Message RAM and circulants.
  localparam int WB_ADDR_WIDTH           = 3;
  localparam int WB_DATA_WIDTH           = 6;
  localparam int WB_BUS_WIDTH            = 18;
  localparam int WB_OFFSET_CH            = 3;
  localparam int WB_LOG2CIRC_SIZE        = 2;
  localparam int WB_NUM_CIRCS            = 12;
  localparam int WB_NEIGHBOR_INDEX_WIDTH = 2;

  // Derived constants for the default geometry.
  localparam int CIRC_SIZE      = 1 << WB_LOG2CIRC_SIZE;
  localparam int FIELDS         = WB_BUS_WIDTH / WB_DATA_WIDTH;
  localparam int IN_FIELD_WIDTH = WB_DATA_WIDTH + 1;

  // Write-back sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } wb_state_t;

  // Same derivations as above, usable with overridden module parameters.
  function automatic int circ_size(input int log2_size);
    return 1 << log2_size;
  endfunction

  function automatic int fields_per_word(input int bus_w, input int data_w);
    return bus_w / data_w;
  endfunction

endpackage : ldpc_qkd_pkg
`default_nettype wire

// File: rtl/msg_saturate.sv
`default_nettype none
// ============================================================================
// Module      : msg_saturate
// Description : Converts one signed message field from IN_WIDTH bits to
//               OUT_WIDTH bits.
//               Config macro MSG_WB_SAT_EN:
//                 defined   - clamp to the OUT_WIDTH two's complement range,
//                             clip=1 whenever the value was clamped.
//                 undefined - keep the low OUT_WIDTH bits, clip tied to 0.
// Ports       : in_field  - signed input field (IN_WIDTH bits)
//               out_field - converted field (OUT_WIDTH bits)
//               clip      - field was clamped this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module msg_saturate #(
  parameter int IN_WIDTH  = 7,
  parameter int OUT_WIDTH = 6
) (
  input  logic [IN_WIDTH-1:0]  in_field,
  output logic [OUT_WIDTH-1:0] out_field,
  output logic                 clip
);

`ifdef MSG_WB_SAT_EN
  // The value fits in OUT_WIDTH bits exactly when every bit from the output
  // sign position upward is a copy of the input sign bit.
  logic [IN_WIDTH-OUT_WIDTH:0] w_top;
  logic                        w_fits;
  logic [OUT_WIDTH-1:0]        w_pos_limit;
  logic [OUT_WIDTH-1:0]        w_neg_limit;

  assign w_top       = in_field[IN_WIDTH-1:OUT_WIDTH-1];
  assign w_fits      = (&w_top) | ~(|w_top);
  assign w_pos_limit = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  assign w_neg_limit = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  assign clip      = ~w_fits;
  assign out_field = w_fits                 ? in_field[OUT_WIDTH-1:0] :
                     in_field[IN_WIDTH-1]   ? w_neg_limit             :
                                              w_pos_limit;
`else
  // Plain truncation: the upper bits are intentionally discarded.
  logic [IN_WIDTH-OUT_WIDTH-1:0] unused_high;

  assign unused_high = in_field[IN_WIDTH-1:OUT_WIDTH];
  assign out_field   = in_field[OUT_WIDTH-1:0];
  assign clip        = 1'b0;
`endif

endmodule : msg_saturate
`default_nettype wire

// File: rtl/message_writeback.sv
`default_nettype none
// ============================================================================
// Module      : message_writeback
// Description : Write side of the decoder Message RAM path. Accepts one beat
//               per circulant node during a phase, converts each field to
//               DATA_WIDTH, forms per-bank write addresses and issues one
//               write per bank into NUM_CIRCS Message RAM banks, one cycle
//               after each accepted beat.
//               Config macro MSG_WB_SAT_EN (in msg_saturate): saturate
//               fields and report clipping on sat_flag; otherwise truncate.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               start               - begin a phase (IDLE only)
//               vr_process          - 1: vr->ch region (base OFFSET_CH)
//               neighbor            - 1: address from in_neighbor_index
//               in_valid / in_ready - beat handshake
//               in_data             - per-bank signed fields, bank 0 in LSBs
//               in_neighbor_index   - per-bank neighbor index
//               mf_we/mf_addr/mf_data_out - Message RAM write port
//               busy                - high outside IDLE
//               phase_done          - pulse with the final write of a phase
//               sat_flag            - sticky clip indicator, cleared by start
// Revision    : 1.0 - initial release
// ============================================================================
module message_writeback
  import ldpc_qkd_pkg::*;
#(
  parameter int ADDR_WIDTH           = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH           = WB_DATA_WIDTH,
  parameter int BUS_WIDTH            = WB_BUS_WIDTH,
  parameter int OFFSET_CH            = WB_OFFSET_CH,
  parameter int LOG2CIRC_SIZE        = WB_LOG2CIRC_SIZE,
  parameter int NUM_CIRCS            = WB_NUM_CIRCS,
  parameter int NEIGHBOR_INDEX_WIDTH = WB_NEIGHBOR_INDEX_WIDTH
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  start,
  input  logic                                                  vr_process,
  input  logic                                                  neighbor,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic [NUM_CIRCS*(BUS_WIDTH/DATA_WIDTH)*(DATA_WIDTH+1)-1:0] in_data,
  input  logic [NUM_CIRCS*NEIGHBOR_INDEX_WIDTH-1:0]            in_neighbor_index,
  output logic                                                  mf_we,
  output logic [NUM_CIRCS*ADDR_WIDTH-1:0]                      mf_addr,
  output logic [NUM_CIRCS*BUS_WIDTH-1:0]                       mf_data_out,
  output logic                                                  busy,
  output logic                                                  phase_done,
  output logic                                                  sat_flag
);

  localparam int CIRC_LEN = circ_size(LOG2CIRC_SIZE);
  localparam int NFIELDS  = fields_per_word(BUS_WIDTH, DATA_WIDTH);
  localparam int IN_FW    = DATA_WIDTH + 1;
  localparam int NSLOTS   = NUM_CIRCS * NFIELDS;
  localparam int NIW      = NEIGHBOR_INDEX_WIDTH;

  localparam logic [LOG2CIRC_SIZE-1:0] LAST_BEAT = LOG2CIRC_SIZE'(CIRC_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0]    VR_BASE   = ADDR_WIDTH'(OFFSET_CH);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  wb_state_t                       state_q,      state_d;
  logic [LOG2CIRC_SIZE-1:0]        count_q,      count_d;
  logic                            vr_q,         vr_d;
  logic                            neighbor_q,   neighbor_d;
  logic                            mf_we_q,      mf_we_d;
  logic                            phase_done_q, phase_done_d;
  logic                            sat_flag_q,   sat_flag_d;
  logic [NUM_CIRCS*ADDR_WIDTH-1:0] mf_addr_q,    mf_addr_d;
  logic [NUM_CIRCS*BUS_WIDTH-1:0]  mf_data_q,    mf_data_d;

  // --------------------------------------------------------------------------
  // Per-bank datapath: field conversion and address generation
  // --------------------------------------------------------------------------
  logic [NUM_CIRCS*ADDR_WIDTH-1:0] w_wr_addr;
  logic [NUM_CIRCS*BUS_WIDTH-1:0]  w_wr_data;
  logic [NSLOTS-1:0]               w_clip;
  logic                            w_any_clip;
  logic                            w_accept;
  logic [ADDR_WIDTH-1:0]           w_base;

  assign w_base = vr_q ? VR_BASE : '0;

  for (genvar k = 0; k < NUM_CIRCS; k++) begin : g_bank
    logic [ADDR_WIDTH-1:0] w_offset;

    // Offset is either the bank's own neighbor index or the shared beat
    // position; the sum wraps naturally modulo 2^ADDR_WIDTH.
    assign w_offset = neighbor_q ? ADDR_WIDTH'(in_neighbor_index[k*NIW +: NIW])
                                 : ADDR_WIDTH'(count_q);
    assign w_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = w_base + w_offset;

    for (genvar f = 0; f < NFIELDS; f++) begin : g_field
      msg_saturate #(
        .IN_WIDTH  (IN_FW),
        .OUT_WIDTH (DATA_WIDTH)
      ) u_sat (
        .in_field  (in_data[(k*NFIELDS+f)*IN_FW +: IN_FW]),
        .out_field (w_wr_data[k*BUS_WIDTH + f*DATA_WIDTH +: DATA_WIDTH]),
        .clip      (w_clip[k*NFIELDS+f])
      );
    end : g_field

    // Word bits beyond the packed fields are written as zero.
    if (BUS_WIDTH > NFIELDS*DATA_WIDTH) begin : g_pad
      assign w_wr_data[k*BUS_WIDTH + NFIELDS*DATA_WIDTH +: BUS_WIDTH - NFIELDS*DATA_WIDTH] = '0;
    end : g_pad
  end : g_bank

  assign w_any_clip = |w_clip;
  assign w_accept   = (state_q == RUN) & in_valid;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    vr_d         = vr_q;
    neighbor_d   = neighbor_q;
    mf_we_d      = 1'b0;
    phase_done_d = 1'b0;
    sat_flag_d   = sat_flag_q;
    mf_addr_d    = mf_addr_q;
    mf_data_d    = mf_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          vr_d       = vr_process;
          neighbor_d = neighbor;
          count_d    = '0;
          sat_flag_d = 1'b0;
        end
      end

      RUN: begin
        if (w_accept) begin
          count_d    = count_q + 1'b1;
          mf_we_d    = 1'b1;
          mf_addr_d  = w_wr_addr;
          mf_data_d  = w_wr_data;
          sat_flag_d = sat_flag_q | w_any_clip;
          // The last beat's write lands in the FLUSH cycle together with
          // the phase_done pulse.
          if (count_q == LAST_BEAT) begin
            state_d      = FLUSH;
            phase_done_d = 1'b1;
          end
        end
      end

      FLUSH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      vr_q         <= 1'b0;
      neighbor_q   <= 1'b0;
      mf_we_q      <= 1'b0;
      phase_done_q <= 1'b0;
      sat_flag_q   <= 1'b0;
      mf_addr_q    <= '0;
      mf_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      vr_q         <= vr_d;
      neighbor_q   <= neighbor_d;
      mf_we_q      <= mf_we_d;
      phase_done_q <= phase_done_d;
      sat_flag_q   <= sat_flag_d;
      mf_addr_q    <= mf_addr_d;
      mf_data_q    <= mf_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready    = (state_q == RUN);
  assign busy        = (state_q != IDLE);
  assign mf_we       = mf_we_q;
  assign mf_addr     = mf_addr_q;
  assign mf_data_out = mf_data_q;
  assign phase_done  = phase_done_q;
  assign sat_flag    = sat_flag_q;

endmodule : message_writeback
`default_nettype wire

// File: tb/tb_message_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_message_writeback
// Description : Self-checking bench for message_writeback. A driver issues
//               directed phases and pushes expected writes into a queue; a
//               monitor pops and compares whenever mf_we is seen. A second
//               instance with OFFSET_CH=7 exercises address wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_message_writeback;

  localparam int NC = 12;
  localparam int AW = 3;
  localparam int DW = 6;
  localparam int BW = 18;
  localparam int FL = 3;
  localparam int IW = 7;
  localparam int NW = 2;
  localparam int CS = 4;

  typedef struct packed {
    logic [NC*AW-1:0] addr;
    logic [NC*AW-1:0] addr_w;
    logic [NC*BW-1:0] data;
    logic             pd;
    logic             sat;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                vr_process = 1'b0;
  logic                neighbor = 1'b0;
  logic                in_valid = 1'b0;
  logic [NC*FL*IW-1:0] in_data = '0;
  logic [NC*NW-1:0]    in_neighbor_index = '0;

  logic                in_ready, mf_we, busy, phase_done, sat_flag;
  logic [NC*AW-1:0]    mf_addr;
  logic [NC*BW-1:0]    mf_data_out;

  logic                w_mf_we, w_phase_done;
  logic [NC*AW-1:0]    w_mf_addr;
  logic                unused_w_ready, unused_w_busy, unused_w_sat;
  logic [NC*BW-1:0]    unused_w_data;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  int   beat;
  bit   cur_vr, cur_nb, model_sat;
  int   nidx[NC];
  logic [NC*AW-1:0] hold_addr, hold_addr_w;
  logic [NC*BW-1:0] hold_data;

  always #5 clk = ~clk;

  message_writeback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vr_process(vr_process),
    .neighbor(neighbor), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_neighbor_index(in_neighbor_index),
    .mf_we(mf_we), .mf_addr(mf_addr), .mf_data_out(mf_data_out),
    .busy(busy), .phase_done(phase_done), .sat_flag(sat_flag)
  );

  message_writeback #(.OFFSET_CH(7)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .vr_process(vr_process),
    .neighbor(neighbor), .in_valid(in_valid), .in_ready(unused_w_ready),
    .in_data(in_data), .in_neighbor_index(in_neighbor_index),
    .mf_we(w_mf_we), .mf_addr(w_mf_addr), .mf_data_out(unused_w_data),
    .busy(unused_w_busy), .phase_done(w_phase_done), .sat_flag(unused_w_sat)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference field conversion from the integer value.
  function automatic logic [DW-1:0] conv(input int v);
    int c;
    c = v;
`ifdef MSG_WB_SAT_EN
    if (c > 31)  c = 31;
    if (c < -32) c = -32;
`endif
    return DW'(c);
  endfunction

  function automatic bit clipped(input int v);
`ifdef MSG_WB_SAT_EN
    return (v > 31) || (v < -32);
`else
    return (v > 1000000);
`endif
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: compares every write against the scoreboard
  // --------------------------------------------------------------------------
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      q.delete();
      hold_addr   = '0;
      hold_addr_w = '0;
      hold_data   = '0;
    end else if (mf_we) begin
      chk("write_expected", 256'(q.size() != 0), 256'(1));
      chk("wrap_inst_we", 256'(w_mf_we), 256'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("mf_addr", 256'(mf_addr), 256'(e.addr));
        chk("mf_addr_wrap", 256'(w_mf_addr), 256'(e.addr_w));
        chk("mf_data_out", 256'(mf_data_out), 256'(e.data));
        chk("phase_done", 256'(phase_done), 256'(e.pd));
        chk("phase_done_wrap", 256'(w_phase_done), 256'(e.pd));
        chk("sat_flag", 256'(sat_flag), 256'(e.sat));
        hold_addr   = e.addr;
        hold_addr_w = e.addr_w;
        hold_data   = e.data;
      end
    end else begin
      chk("wrap_inst_we_idle", 256'(w_mf_we), 256'(0));
      chk("phase_done_idle", 256'(phase_done), 256'(0));
      chk("mf_addr_hold", 256'(mf_addr), 256'(hold_addr));
      chk("mf_addr_wrap_hold", 256'(w_mf_addr), 256'(hold_addr_w));
      chk("mf_data_hold", 256'(mf_data_out), 256'(hold_data));
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic start_phase(input bit vr, input bit nb);
    cur_vr = vr; cur_nb = nb; beat = 0; model_sat = 0;
    for (int k = 0; k < NC; k++) in_neighbor_index[k*NW +: NW] = NW'(nidx[k]);
    vr_process = vr; neighbor = nb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; vr_process = ~vr; neighbor = ~nb;   // must have been latched
    chk("in_ready_after_start", 256'(in_ready), 256'(1));
    chk("busy_after_start", 256'(busy), 256'(1));
    chk("sat_flag_cleared", 256'(sat_flag), 256'(0));
  endtask

  // Offers one beat (mode 1 puts +40/-40 into bank 0 fields 0/1).
  task automatic send_beat(input int mode, input bit keep_valid);
    exp_t e;
    int   v, off;
    e = '0;
    for (int k = 0; k < NC; k++) begin
      for (int f = 0; f < FL; f++) begin
        v = ((k*3 + f + beat*5) % 40) - 20;
        if (mode == 1 && k == 0 && f == 0) v = 40;
        if (mode == 1 && k == 0 && f == 1) v = -40;
        in_data[(k*FL+f)*IW +: IW] = IW'(v);
        e.data[k*BW + f*DW +: DW] = conv(v);
        if (clipped(v)) model_sat = 1;
      end
      off = cur_nb ? nidx[k] : beat;
      e.addr[k*AW +: AW]   = AW'((cur_vr ? 3 : 0) + off);
      e.addr_w[k*AW +: AW] = AW'((cur_vr ? 7 : 0) + off);
    end
    e.pd  = (beat == CS-1);
    e.sat = model_sat;
    chk("in_ready_run", 256'(in_ready), 256'(1));
    q.push_back(e);
    in_valid = 1'b1;
    beat++;
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic check_flush_then_idle();
    chk("flush_in_ready", 256'(in_ready), 256'(0));
    chk("flush_busy", 256'(busy), 256'(1));
    chk("flush_phase_done", 256'(phase_done), 256'(1));
    @(negedge clk);
    chk("idle_busy", 256'(busy), 256'(0));
    chk("idle_in_ready", 256'(in_ready), 256'(0));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 256'(in_ready), 256'(0));
    chk({tag, "_mf_we"}, 256'(mf_we), 256'(0));
    chk({tag, "_mf_addr"}, 256'(mf_addr), 256'(0));
    chk({tag, "_mf_data"}, 256'(mf_data_out), 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_phase_done"}, 256'(phase_done), 256'(0));
    chk({tag, "_sat_flag"}, 256'(sat_flag), 256'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    bit sat_exp;
    for (int k = 0; k < NC; k++) nidx[k] = k % 4;

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic ch->vr phase, beat-counter addressing.
    start_phase(1'b0, 1'b0);
    for (int i = 0; i < CS; i++) send_beat(0, 1'b0);
    check_flush_then_idle();
    @(negedge clk);

    // vr->ch phase with neighbor addressing (bank0=2, bank11=3).
    nidx[0] = 2; nidx[11] = 3;
    start_phase(1'b1, 1'b1);
    for (int i = 0; i < CS; i++) send_beat(0, 1'b0);
    check_flush_then_idle();

    // Saturation / truncation of +40 and -40.
    start_phase(1'b0, 1'b0);
    send_beat(1, 1'b0);
    for (int i = 1; i < CS; i++) send_beat(0, 1'b0);
    sat_exp = model_sat;
    check_flush_then_idle();
    repeat (2) @(negedge clk);
`ifdef MSG_WB_SAT_EN
    chk("sat_flag_sticky", 256'(sat_flag), 256'(1));
`else
    chk("sat_flag_off", 256'(sat_flag), 256'(0));
`endif
    chk("sat_flag_model", 256'(sat_flag), 256'(sat_exp));

    // Handshake: valid 1,0,1,1,0,1; start pulsed during RUN is ignored;
    // in_valid held through FLUSH and IDLE is never accepted.
    start_phase(1'b1, 1'b0);
    send_beat(0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_beat(0, 1'b0);
    send_beat(0, 1'b0);
    @(negedge clk);
    send_beat(0, 1'b1);
    check_flush_then_idle();
    @(negedge clk);
    chk("idle_valid_not_taken", 256'(busy), 256'(0));
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a phase.
    start_phase(1'b0, 1'b0);
    send_beat(0, 1'b0);
    send_beat(0, 1'b0);
    rst_n = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("midreset_idle_busy", 256'(busy), 256'(0));
    chk("midreset_idle_ready", 256'(in_ready), 256'(0));

    // A normal phase still works after the reset.
    nidx[5] = 1;
    start_phase(1'b1, 1'b1);
    for (int i = 0; i < CS; i++) send_beat(0, 1'b0);
    check_flush_then_idle();
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", 256'(q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_message_writeback
`default_nettype wire
